pkt_tx: RTL and testbench

Egress packet transmitter for an SRAM-controller output port. It accepts packet words from the switching core into a store-and-forward buffer. For each complete packet it emits the port framing used by the ingress FIFO: a one-cycle sop pulse, then consecutive vld data words, then a one-cycle eop pulse, with no backpressure from the port. It is the sending end of the sop/vld/eop interface that the ingress FIFO receives.

---
 rtl/pkt_tx_pkg.sv | 32 +++
 rtl/pkt_tx_buf.sv | 39 +++
 rtl/pkt_tx.sv | 259 +++++++++++++++++++++++++
 tb/tb_pkt_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_tx_pkg
//  Purpose  : Shared definitions for the pkt_tx egress transmitter: read-FSM
//             state encoding and helpers that derive the buffer entry width
//             and the extended pointer width from the block parameters.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pkt_tx_pkg;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SOP  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_EOP  = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  // Buffer entry is {last, data}.
  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

  // One extra pointer bit distinguishes full from empty.
  function automatic int ptr_q_width(input int ptr_width);
    return ptr_width + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_tx_buf.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_tx_buf
//  Purpose  : Store-and-forward packet storage: DEPTH x ENTRY_W register
//             array, one synchronous write port, one asynchronous read port.
//  Ports    : clk       - clock
//             wr_en     - write strobe
//             wr_addr   - write index
//             wr_entry  - {last, data} entry to store
//             rd_addr   - read index
//             rd_entry  - entry at rd_addr (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module pkt_tx_buf #(
  parameter int DEPTH     = 32,
  parameter int PTR_WIDTH = 5,
  parameter int ENTRY_W   = 65
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [PTR_WIDTH-1:0] wr_addr,
  input  logic [ENTRY_W-1:0]   wr_entry,
  input  logic [PTR_WIDTH-1:0] rd_addr,
  output logic [ENTRY_W-1:0]   rd_entry
);

  // Payload storage carries no reset; validity is tracked by the pointers.
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_entry;
    end
  end

  assign rd_entry = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_tx
//  Purpose  : Egress packet transmitter. Buffers whole packets from the core
//             and emits sop / vld-data / eop framing toward the port.
//  Ports    : clk       - clock, rising edge
//             rst       - asynchronous reset, active low
//             in_vld    - core word valid
//             in_last   - final word of packet (qualified by in_vld)
//             in_data   - core word
//             in_ready  - word accepted when in_vld && in_ready
//             out_sop   - start-of-packet pulse (no data)
//             out_eop   - end-of-packet pulse (no data)
//             out_vld   - out_data valid
//             out_data  - packet word, 0 when out_vld is low
//             pkt_cnt   - complete packets currently buffered
//             overflow  - sticky packet-dropped flag
//  Revision : 1.0 - initial release
// ============================================================================
module pkt_tx
  import pkt_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 32,
  parameter int PTR_WIDTH  = 5,
  parameter int IFG        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [PTR_WIDTH:0]    pkt_cnt,
  output logic                  overflow
);

  localparam int ENTRY_W = entry_width(DATA_WIDTH);
  localparam int PQ_W    = ptr_q_width(PTR_WIDTH);
  localparam int GAP_W   = $clog2(IFG + 2);

  localparam logic [PQ_W-1:0]  DEPTH_Q  = PQ_W'(DEPTH);
  localparam logic [PQ_W-1:0]  PTR_ONE  = PQ_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IFG > 0) ? IFG - 1 : 0);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PQ_W-1:0]       wptr_q, wptr_d;
  logic [PQ_W-1:0]       rptr_q, rptr_d;
  logic [PQ_W-1:0]       pkt_start_q, pkt_start_d;
  logic [PQ_W-1:0]       pkt_cnt_q, pkt_cnt_d;
  logic                  dropping_q, dropping_d;
  logic                  overflow_q, overflow_d;
  state_t                state_q, state_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  cur_last_q, cur_last_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  // --------------------------------------------------------------------------
  // Occupancy and input handshake
  // --------------------------------------------------------------------------
  logic [PQ_W-1:0]    count;
  logic               full;
  logic               accept;
  logic               wr_en;
  logic               drop_start;
  logic               pkt_inc;
  logic               pkt_dec;
  logic [ENTRY_W-1:0] rd_entry;

  assign count    = wptr_q - rptr_q;
  assign full     = (count == DEPTH_Q);
  // While dropping the input must keep flowing so the oversized packet can
  // be swallowed up to its last word, even though the buffer is full.
  assign in_ready = !full || dropping_q;
  assign accept   = in_vld && in_ready;
  assign wr_en    = accept && !dropping_q;
  assign pkt_inc  = wr_en && in_last;

  // A full buffer with no complete packet can only hold a single packet that
  // is too large to ever fit; it is abandoned back to the last packet start.
  assign drop_start = full && (pkt_cnt_q == '0) && !dropping_q;

  pkt_tx_buf #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH),
    .ENTRY_W   (ENTRY_W)
  ) u_buf (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_addr  (wptr_q[PTR_WIDTH-1:0]),
    .wr_entry ({in_last, in_data}),
    .rd_addr  (rptr_q[PTR_WIDTH-1:0]),
    .rd_entry (rd_entry)
  );

  // --------------------------------------------------------------------------
  // Write side
  // --------------------------------------------------------------------------
  always_comb begin
    wptr_d      = wptr_q;
    pkt_start_d = pkt_start_q;
    dropping_d  = dropping_q;
    overflow_d  = overflow_q;

    if (drop_start) begin
      wptr_d     = pkt_start_q;
      overflow_d = 1'b1;
      dropping_d = 1'b1;
    end else if (wr_en) begin
      wptr_d = wptr_q + PTR_ONE;
      if (in_last) begin
        pkt_start_d = wptr_q + PTR_ONE;
      end
    end

    if (dropping_q && accept && in_last) begin
      dropping_d = 1'b0;
    end
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    unique case ({pkt_inc, pkt_dec})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read FSM. Output registers are loaded together with the state, so the
  // state register always names what is on the port this cycle. The packet
  // count is decremented on the edge that enters EOP, which lets EOP/GAP
  // chain straight into the next SOP when more packets are waiting.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rptr_d     = rptr_q;
    gap_d      = gap_q;
    cur_last_d = cur_last_q;
    out_sop_d  = 1'b0;
    out_eop_d  = 1'b0;
    out_vld_d  = 1'b0;
    out_data_d = '0;
    pkt_dec    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pkt_cnt_q != '0) begin
          state_d   = ST_SOP;
          out_sop_d = 1'b1;
        end
      end

      ST_SOP: begin
        state_d    = ST_DATA;
        out_vld_d  = 1'b1;
        out_data_d = rd_entry[DATA_WIDTH-1:0];
        cur_last_d = rd_entry[DATA_WIDTH];
        rptr_d     = rptr_q + PTR_ONE;
      end

      ST_DATA: begin
        if (cur_last_q) begin
          state_d   = ST_EOP;
          out_eop_d = 1'b1;
          pkt_dec   = 1'b1;
        end else begin
          out_vld_d  = 1'b1;
          out_data_d = rd_entry[DATA_WIDTH-1:0];
          cur_last_d = rd_entry[DATA_WIDTH];
          rptr_d     = rptr_q + PTR_ONE;
        end
      end

      ST_EOP: begin
        if (IFG > 0) begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end else if (pkt_cnt_q != '0) begin
          state_d   = ST_SOP;
          out_sop_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          if (pkt_cnt_q != '0) begin
            state_d   = ST_SOP;
            out_sop_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      pkt_start_q <= '0;
      pkt_cnt_q   <= '0;
      dropping_q  <= 1'b0;
      overflow_q  <= 1'b0;
      state_q     <= ST_IDLE;
      gap_q       <= '0;
      cur_last_q  <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      pkt_start_q <= pkt_start_d;
      pkt_cnt_q   <= pkt_cnt_d;
      dropping_q  <= dropping_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      gap_q       <= gap_d;
      cur_last_q  <= cur_last_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_sop  = out_sop_q;
  assign out_eop  = out_eop_q;
  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pkt_tx
//  Purpose  : Self-checking bench for pkt_tx. A cycle table drives an IFG=1
//             instance and an IFG=0 instance in parallel; directed sequences
//             cover store-and-forward, oversize drop, reset and backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_tx;

  localparam int DW = 64;
  localparam int PW = 5;

  logic          clk;
  logic          rst;
  logic          in_vld;
  logic          in_last;
  logic [DW-1:0] in_data;

  logic          in_ready, out_sop, out_eop, out_vld, overflow;
  logic [DW-1:0] out_data;
  logic [PW:0]   pkt_cnt;

  logic          z_in_ready, z_out_sop, z_out_eop, z_out_vld, z_overflow;
  logic [DW-1:0] z_out_data;
  logic [PW:0]   z_pkt_cnt;

  pkt_tx #(.DATA_WIDTH(DW), .DEPTH(32), .PTR_WIDTH(PW), .IFG(1)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready), .out_sop(out_sop), .out_eop(out_eop), .out_vld(out_vld),
    .out_data(out_data), .pkt_cnt(pkt_cnt), .overflow(overflow)
  );

  pkt_tx #(.DATA_WIDTH(DW), .DEPTH(32), .PTR_WIDTH(PW), .IFG(0)) dut0 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_last(in_last), .in_data(in_data),
    .in_ready(z_in_ready), .out_sop(z_out_sop), .out_eop(z_out_eop), .out_vld(z_out_vld),
    .out_data(z_out_data), .pkt_cnt(z_pkt_cnt), .overflow(z_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int sop_seen = 0;
  int ready_low = 0;

  always @(negedge clk) begin
    #1;
    if (out_sop === 1'b1) sop_seen++;
    if (in_vld === 1'b1 && in_ready === 1'b0) ready_low++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out", name);
  endtask

  // Output kinds used in the cycle table.
  localparam int K0 = 0, KS = 1, KV = 2, KE = 3;

  typedef struct {
    logic          vld;
    logic          last;
    logic [DW-1:0] data;
    int            e_kind;
    logic [DW-1:0] e_data;
    logic [PW:0]   e_cnt;
    int            z_kind;
    logic [DW-1:0] z_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic l, input logic [DW-1:0] d,
                              input int ek, input logic [DW-1:0] ed, input logic [PW:0] ec,
                              input int zk, input logic [DW-1:0] zd);
    vec_t r;
    r.vld = v; r.last = l; r.data = d;
    r.e_kind = ek; r.e_data = ed; r.e_cnt = ec;
    r.z_kind = zk; r.z_data = zd;
    return r;
  endfunction

  function automatic logic [2:0] kflags(input int k);
    case (k)
      KS:      return 3'b100;
      KV:      return 3'b010;
      KE:      return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Called at a negedge; drives one packet with handshake, returns at the
  // negedge following the edge that accepted the final word.
  task automatic send_pkt(input logic [DW-1:0] base, input int n, input bit with_last);
    int t;
    for (int i = 0; i < n; i++) begin
      in_vld  = 1'b1;
      in_data = base + DW'(i);
      in_last = with_last && (i == n - 1);
      t = 0;
      while (in_ready !== 1'b1 && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) timeout_fail("send in_ready");
      @(negedge clk);
    end
    in_vld  = 1'b0;
    in_last = 1'b0;
    in_data = '0;
  endtask

  // Called at a negedge; waits for sop then checks n consecutive words and eop.
  task automatic expect_pkt(input logic [DW-1:0] base, input int n, input string name);
    int t = 0;
    while (out_sop !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check({name, " sop"}, {127'd0, out_sop}, 128'd1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({name, " word"}, {out_sop, out_eop, out_vld, out_data},
            {1'b0, 1'b0, 1'b1, DW'(base + DW'(i))});
    end
    @(negedge clk);
    check({name, " eop"}, {out_sop, out_eop, out_vld, out_data}, {3'b010, {DW{1'b0}}});
  endtask

  initial begin
    logic saw;
    int   s0;
    int   t;

    rst = 1'b0; in_vld = 1'b0; in_last = 1'b0; in_data = '0;

    // Single packet A,B,C.
    vecs.push_back(mk(1, 0, 'hA, K0, 0, 0, K0, 0));
    vecs.push_back(mk(1, 0, 'hB, K0, 0, 0, K0, 0));
    vecs.push_back(mk(1, 1, 'hC, K0, 0, 0, K0, 0));
    vecs.push_back(mk(0, 0, 0,   K0, 0, 1, K0, 0));
    vecs.push_back(mk(0, 0, 0,   KS, 0, 1, KS, 0));
    vecs.push_back(mk(0, 0, 0,   KV, 'hA, 1, KV, 'hA));
    vecs.push_back(mk(0, 0, 0,   KV, 'hB, 1, KV, 'hB));
    vecs.push_back(mk(0, 0, 0,   KV, 'hC, 1, KV, 'hC));
    vecs.push_back(mk(0, 0, 0,   KE, 0, 0, KE, 0));
    vecs.push_back(mk(0, 0, 0,   K0, 0, 0, K0, 0));
    vecs.push_back(mk(0, 0, 0,   K0, 0, 0, K0, 0));
    // Two 2-word packets back to back; dut has IFG=1, dut0 has IFG=0.
    vecs.push_back(mk(1, 0, 'h11, K0, 0, 0, K0, 0));
    vecs.push_back(mk(1, 1, 'h12, K0, 0, 0, K0, 0));
    vecs.push_back(mk(1, 0, 'h21, K0, 0, 1, K0, 0));
    vecs.push_back(mk(1, 1, 'h22, KS, 0, 1, KS, 0));
    vecs.push_back(mk(0, 0, 0,    KV, 'h11, 2, KV, 'h11));
    vecs.push_back(mk(0, 0, 0,    KV, 'h12, 2, KV, 'h12));
    vecs.push_back(mk(0, 0, 0,    KE, 0, 1, KE, 0));
    vecs.push_back(mk(0, 0, 0,    K0, 0, 1, KS, 0));
    vecs.push_back(mk(0, 0, 0,    KS, 0, 1, KV, 'h21));
    vecs.push_back(mk(0, 0, 0,    KV, 'h21, 1, KV, 'h22));
    vecs.push_back(mk(0, 0, 0,    KV, 'h22, 1, KE, 0));
    vecs.push_back(mk(0, 0, 0,    KE, 0, 0, K0, 0));
    vecs.push_back(mk(0, 0, 0,    K0, 0, 0, K0, 0));

    repeat (3) @(negedge clk);
    check("reset state", {out_sop, out_eop, out_vld, out_data, pkt_cnt, overflow, in_ready},
          {3'b000, {DW{1'b0}}, {(PW+1){1'b0}}, 1'b0, 1'b1});
    rst = 1'b1;

    foreach (vecs[i]) begin
      in_vld  = vecs[i].vld;
      in_last = vecs[i].last;
      in_data = vecs[i].data;
      check($sformatf("row %0d", i), {out_sop, out_vld, out_eop, out_data, pkt_cnt, in_ready},
            {kflags(vecs[i].e_kind), vecs[i].e_data, vecs[i].e_cnt, 1'b1});
      check($sformatf("row %0d ifg0", i), {z_out_sop, z_out_vld, z_out_eop, z_out_data},
            {kflags(vecs[i].z_kind), vecs[i].z_data});
      @(negedge clk);
    end
    in_vld = 1'b0; in_last = 1'b0; in_data = '0;

    // Store-and-forward: nothing leaves until the last word arrives.
    send_pkt('h300, 4, 1'b0);
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      saw = saw | out_sop;
    end
    check("saf no sop", {127'd0, saw}, 128'd0);
    check("saf cnt0", {122'd0, pkt_cnt}, 128'd0);
    send_pkt('h304, 1, 1'b1);
    check("saf cnt1", {122'd0, pkt_cnt}, 128'd1);
    expect_pkt('h300, 5, "saf");

    // Oversize drop: 40 words into a 32-entry buffer. in_ready is low for the
    // single full cycle before the drop takes effect, then high while dropping.
    repeat (3) @(negedge clk);
    check("pre-drop overflow", {127'd0, overflow}, 128'd0);
    s0 = sop_seen;
    ready_low = 0;
    send_pkt('h400, 40, 1'b1);
    repeat (5) @(negedge clk);
    check("drop overflow", {127'd0, overflow}, 128'd1);
    check("drop ready low cycles", 128'(ready_low), 128'd1);
    check("drop no output", 128'(sop_seen - s0), 128'd0);
    check("drop cnt", {122'd0, pkt_cnt}, 128'd0);
    check("drop in_ready", {127'd0, in_ready}, 128'd1);
    send_pkt('h500, 2, 1'b1);
    expect_pkt('h500, 2, "post-drop");

    // Asynchronous reset in the middle of DATA.
    send_pkt('h600, 8, 1'b1);
    t = 0;
    while (out_vld !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) timeout_fail("reset wait vld");
    #2 rst = 1'b0;
    #1;
    check("reset mid-pkt", {out_sop, out_eop, out_vld, out_data, pkt_cnt, overflow, in_ready},
          {3'b000, {DW{1'b0}}, {(PW+1){1'b0}}, 1'b0, 1'b1});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    send_pkt('h700, 1, 1'b1);
    expect_pkt('h700, 1, "post-reset");

    // Backpressure: short packets build up a backlog so the two 20-word
    // packets push the buffer to full.
    ready_low = 0;
    fork
      begin
        for (int k = 0; k < 12; k++) send_pkt(DW'('h800 + k), 1, 1'b1);
        send_pkt('h900, 20, 1'b1);
        send_pkt('hA00, 20, 1'b1);
      end
      begin
        for (int k = 0; k < 12; k++) expect_pkt(DW'('h800 + k), 1, "bp small");
        expect_pkt('h900, 20, "bp pktA");
        expect_pkt('hA00, 20, "bp pktB");
      end
    join
    check("bp ready went low", {127'd0, (ready_low > 0)}, 128'd1);
    check("bp overflow", {127'd0, overflow}, 128'd0);
    repeat (3) @(negedge clk);
    check("bp cnt", {122'd0, pkt_cnt}, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
